// File: rtl/pbdebounce_array.sv
// Multi-channel push-button debouncer: two-flop synchronisers, one shared sample prescaler,
// per-channel shift-register history, edge pulses and a once-per-press long-hold pulse.
module pbdebounce_array #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HOLD_TICKS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held,
  output logic                tick
);

  localparam int unsigned CntW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS);
  localparam logic [HoldW-1:0] HoldPre = HoldW'(HOLD_TICKS - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CntW-1:0]     presc;
  logic [DEPTH-1:0]    hist      [CHANNELS];
  logic [DEPTH-1:0]    hist_next [CHANNELS];
  logic [HoldW-1:0]    hold_cnt  [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (presc == CntMax) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == CntMax);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hist_next[i] = {hist[i][DEPTH-2:0], sync2[i]};
    end
  end

  // The decision uses the post-shift history so level moves on the very tick that completes a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      held  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hist[i]     <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      held <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          hist[i] <= hist_next[i];
          if (!level[i] && (&hist_next[i])) begin
            level[i] <= 1'b1;
            rise[i]  <= 1'b1;
          end else if (level[i] && !(|hist_next[i])) begin
            level[i] <= 1'b0;
            fall[i]  <= 1'b1;
          end
        end
        // Saturation at HOLD_TICKS keeps held to a single pulse per press.
        if (!level[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && (hold_cnt[i] != HoldMax)) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          held[i]     <= (hold_cnt[i] == HoldPre);
        end
      end
    end
  end

endmodule

// File: tb/tb_pbdebounce_array.sv
// Scoreboard bench: a run-length reference model queues expected outputs per clock, a negedge
// monitor pops and compares; directed scenarios add latency and pulse-count checks.
module tb_pbdebounce_array;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int DP = 4;
  localparam int HT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] level, rise, fall, held;
  logic          tick;

  always #5 clk = ~clk;

  pbdebounce_array #(
    .CHANNELS  (CH),
    .TICK_DIV  (TD),
    .DEPTH     (DP),
    .HOLD_TICKS(HT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .held  (held),
    .tick  (tick)
  );

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] held;
    logic          tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cnt[CH];
  int   fall_cnt[CH];
  int   held_cnt[CH];

  // Reference model: sample delay line, cycle arithmetic for ticks, run lengths for histories.
  bit [CH-1:0] m_s1, m_s2, m_lvl;
  bit          m_last[CH];
  int          m_run[CH];
  int          m_hc[CH];
  int          m_n;

  always @(posedge clk) begin
    exp_t e;
    bit   tick_edge;
    bit   smp;
    bit   lo;
    cyc++;
    e = '0;
    if (rst) begin
      m_s1 = '0;
      m_s2 = '0;
      m_lvl = '0;
      m_n = 0;
      for (int i = 0; i < CH; i++) begin
        m_last[i] = 1'b0;
        m_run[i]  = DP;
        m_hc[i]   = 0;
      end
    end else begin
      m_n++;
      tick_edge = ((m_n - 1) % TD) == TD - 1;
      if (tick_edge) begin
        for (int i = 0; i < CH; i++) begin
          smp = m_s2[i];
          lo  = m_lvl[i];
          if (lo) begin
            if (m_hc[i] < HT) begin
              m_hc[i]++;
              if (m_hc[i] == HT) e.held[i] = 1'b1;
            end
          end else begin
            m_hc[i] = 0;
          end
          if (smp == m_last[i]) begin
            m_run[i] = (m_run[i] + 1 > DP) ? DP : m_run[i] + 1;
          end else begin
            m_last[i] = smp;
            m_run[i]  = 1;
          end
          if (m_run[i] >= DP && m_last[i] != lo) begin
            m_lvl[i] = m_last[i];
            if (m_last[i]) e.rise[i] = 1'b1;
            else e.fall[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = button;
      e.level = m_lvl;
      e.tick  = (m_n % TD) == TD - 1;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    a = {level, rise, fall, held, tick};
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i] += int'(rise[i]);
      fall_cnt[i] += int'(fall[i]);
      held_cnt[i] += int'(held[i]);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty cyc=%0d got=%h required=an expected entry", cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (rst) e = '0;
      if (a !== e) begin
        n_bad++;
        if (n_bad < 30)
          $display("FAIL cycle_outputs cyc=%0d got=%h required=%h", cyc, a, e);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // kind: 0 rise, 1 fall, 2 held, 3 tick; lat = clk edges since t0, or -1 on timeout
  task automatic wait_sig(input int ch, input int kind, input int t0, input int bound,
                          output int lat);
    logic s;
    lat = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      case (kind)
        0:       s = rise[ch];
        1:       s = fall[ch];
        2:       s = held[ch];
        default: s = tick;
      endcase
      if (s) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, base_r, base_h, base_f;
    int rem[CH];
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      held_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_level", int'(level), 0);
    rst = 1'b0;

    // Tick: high in the 4th cycle after release, period TD, one cycle wide.
    t0 = cyc;
    wait_sig(0, 3, t0, 10, lat);
    check("tick_first_edges", lat, TD - 1);
    @(negedge clk);
    check("tick_width", int'(tick), 0);
    t0 = cyc - 1;
    wait_sig(0, 3, t0, 10, lat);
    check("tick_period", lat, TD);

    // Single clean press on channel 0.
    @(negedge clk);
    button[0] = 1'b1;
    t0 = cyc;
    wait_sig(0, 0, t0, 30, lat);
    check("rise0_latency_in_15_18", int'(lat >= 15 && lat <= 18), 1);
    check("rise0_others_quiet", int'(level[3:1]), 0);
    button[0] = 1'b0;
    wait_sig(0, 1, cyc, 30, lat);
    check("fall0_seen", int'(lat > 0), 1);

    // Short burst on channel 1 is absorbed.
    base_r = rise_cnt[1];
    base_f = fall_cnt[1];
    button[1] = 1'b1;
    repeat (8) @(negedge clk);
    button[1] = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch1_no_rise", rise_cnt[1] - base_r, 0);
    check("glitch1_no_fall", fall_cnt[1] - base_f, 0);

    // Long press on channel 2: one rise, one held 20 clocks later.
    base_r = rise_cnt[2];
    base_h = held_cnt[2];
    button[2] = 1'b1;
    wait_sig(2, 0, cyc, 30, lat);
    t0 = cyc;
    wait_sig(2, 2, t0, 40, lat);
    check("held2_after_rise", lat, TD * HT);
    repeat (40) @(negedge clk);
    check("held2_once", held_cnt[2] - base_h, 1);
    check("rise2_once", rise_cnt[2] - base_r, 1);
    button[2] = 1'b0;
    wait_sig(2, 1, cyc, 30, lat);
    check("fall2_seen", int'(lat > 0), 1);

    // Simultaneous press and release on channels 0 and 3.
    button[0] = 1'b1;
    button[3] = 1'b1;
    wait_sig(0, 0, cyc, 30, lat);
    check("rise3_with_rise0", int'(rise[3]), 1);
    button[0] = 1'b0;
    button[3] = 1'b0;
    wait_sig(0, 1, cyc, 30, lat);
    check("fall3_with_fall0", int'(fall[3]), 1);

    // Reset mid-hold (hold counter 3) with button still high.
    button[2] = 1'b1;
    wait_sig(2, 0, cyc, 30, lat);
    repeat (3 * TD) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", int'({level, rise, fall, held, tick}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    wait_sig(2, 0, t0, 30, lat);
    check("rise2_after_reset", lat, DP * TD);
    t0 = cyc;
    wait_sig(2, 2, t0, 40, lat);
    check("held2_after_reset", lat, TD * HT);
    button[2] = 1'b0;
    repeat (30) @(negedge clk);

    // Random bouncing, mixing sub-threshold glitches and stable stretches.
    for (int i = 0; i < CH; i++) rem[i] = $urandom_range(1, 40);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          button[i] = ~button[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TD * (DP - 1) - 1))
                                                : int'($urandom_range(12, 70));
        end
      end
    end
    button = '0;
    repeat (60) @(negedge clk);
    check("final_levels_low", int'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pbdebounce_array.md
PBDEBOUNCE_ARRAY -- requirements
Module: pbdebounce_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, the number of independent push-button channels (>=1).
REQ-002 SHALL have parameter TICK_DIV, default 50000, the clk cycles per sample tick (>=2; 1 ms at 50 MHz).
REQ-003 SHALL have parameter DEPTH, default 8, the consecutive identical samples required to change state (>=2).
REQ-004 SHALL have parameter HOLD_TICKS, default 1000, the ticks of continuous press before a long-press pulse (>=1).
REQ-005 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port button  input  CHANNELS  raw asynchronous button levels, bit i = channel i.
REQ-008 SHALL have port level  output  CHANNELS  debounced level per channel, registered.
REQ-009 SHALL have port rise  output  CHANNELS  one-clk pulse on debounced 0->1.
REQ-010 SHALL have port fall  output  CHANNELS  one-clk pulse on debounced 1->0.
REQ-011 SHALL have port held  output  CHANNELS  one-clk pulse when a press reaches HOLD_TICKS.
REQ-012 SHALL have port tick  output  1  one-clk strobe marking each sample instant.

Function
REQ-013 SHALL synchronise each button bit through two flip-flops before any other use.
REQ-014 SHALL run one shared prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick SHALL be high exactly in the cycle the count equals TICK_DIV-1.
REQ-015 SHALL use tick only as a clock enable; no derived or gated clocks.
REQ-016 SHALL, on each tick edge, shift each channel's synchronised sample into its DEPTH-bit history.
REQ-017 SHALL set level[i] to 1 on the tick edge at which history[i] becomes all ones while level[i]=0, and clear it on the tick edge at which history[i] becomes all zeros while level[i]=1.
REQ-018 SHALL hold level[i] unchanged while history[i] contains mixed values.
REQ-019 SHALL assert rise[i]/fall[i] for exactly the one clk cycle in which level[i] first shows its new value; never both in one cycle.
REQ-020 SHALL keep a per-channel hold counter: cleared while level[i]=0, incremented on each tick while level[i]=1, saturating at HOLD_TICKS.
REQ-021 SHALL pulse held[i] for one clk cycle when its hold counter reaches HOLD_TICKS, once per press; no repeat until release and a new press.
REQ-022 SHALL size counters to hold TICK_DIV-1 and HOLD_TICKS without overflow.
REQ-023 SHALL process channels fully independently; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 SHALL produce a debounced change no later than 2 + TICK_DIV*DEPTH clk edges after a clean input step, and no earlier than 2 + TICK_DIV*(DEPTH-1) + 1.
REQ-025 SHALL drop a glitch shorter than TICK_DIV*(DEPTH-1) clk cycles without any output change.

Reset
REQ-026 SHALL, while rst=1, force synchronisers, histories, prescaler, hold counters, level, rise, fall, held and tick to 0.
REQ-027 SHALL treat reset asserted mid-operation (mid-press, mid-hold) identically to power-on, with no pulses emitted during or on release of reset.
REQ-028 SHALL, if a button is already high at reset release, report level=1 with a rise pulse after DEPTH ticks, like any other press.

Verification (bench parameters CHANNELS=4, TICK_DIV=4, DEPTH=4, HOLD_TICKS=5)
REQ-029 SHALL cover: button[0] 0->1 steady -> level[0]=1 and one rise[0] pulse between clk edges 15 and 18 after the step; other channels stay 0.
REQ-030 SHALL cover: button[1] high 8 clk cycles then low -> level[1], rise[1], fall[1] remain 0 throughout.
REQ-031 SHALL cover: button[2] held high 60 clk cycles -> rise[2] once, then held[2] exactly once 5 ticks (20 clk) after level[2] rises, no further held[2] pulses.
REQ-032 SHALL cover: button[0] and button[3] switched in the same cycle -> rise[0] and rise[3] pulse in the same cycle; on release, fall[0] and fall[3] pulse in the same cycle.
REQ-033 SHALL cover: rst asserted for 3 clk cycles while level[2]=1 and its hold counter=3 -> all outputs 0 immediately (asynchronous); after release with button[2] still high, rise[2] recurs after 4 ticks and held[2] 5 ticks later.
REQ-034 SHALL cover: tick checked for period exactly 4 clk cycles, one cycle wide, first strobe 4 cycles after rst release.
